// File: rtl/reg_writeback_ctrl_pkg.sv
// Shared types and constants for the register write-back controller.
// Contents: default data/address widths, the buffered write entry type and
// the architectural zero register index.
// Optional feature macro used by the block: REG_WB_FORWARD_EN.
package reg_wb_pkg;

    localparam int unsigned WB_DATA_W = 32;
    localparam int unsigned WB_ADDR_W = 5;

    // One pending register file write.
    typedef struct packed {
        logic [WB_ADDR_W-1:0] rd;
        logic [WB_DATA_W-1:0] data;
    } wb_entry_t;

    localparam logic [WB_ADDR_W-1:0] REG_ZERO = '0;

endpackage

// File: rtl/reg_writeback_ctrl_if.sv
// Bus bundle of the write-back controller.
// Signals: ALU and load result channels (valid/ready/rd/data), the registered
// register file write port (wb_en/wb_addr/wb_data), the decode scoreboard
// query (rs1/rs2 -> busy_rs1/busy_rs2) and FIFO occupancy (pending_count).
// With REG_WB_FORWARD_EN defined, youngest-value forwarding outputs are added.
// master: the surrounding pipeline; slave: reg_writeback_ctrl.
interface reg_wb_if
    import reg_wb_pkg::*;
#(
    parameter int unsigned DATA_W     = WB_DATA_W,
    parameter int unsigned ADDR_W     = WB_ADDR_W,
    parameter int unsigned FIFO_DEPTH = 4
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic              alu_valid;
    logic              alu_ready;
    logic [ADDR_W-1:0] alu_rd;
    logic [DATA_W-1:0] alu_data;
    logic              mem_valid;
    logic              mem_ready;
    logic [ADDR_W-1:0] mem_rd;
    logic [DATA_W-1:0] mem_data;
    logic              wb_en;
    logic [ADDR_W-1:0] wb_addr;
    logic [DATA_W-1:0] wb_data;
    logic [ADDR_W-1:0] rs1;
    logic [ADDR_W-1:0] rs2;
    logic              busy_rs1;
    logic              busy_rs2;
    logic [CNT_W-1:0]  pending_count;
`ifdef REG_WB_FORWARD_EN
    logic              fwd_rs1_valid;
    logic [DATA_W-1:0] fwd_rs1_data;
    logic              fwd_rs2_valid;
    logic [DATA_W-1:0] fwd_rs2_data;
`endif

    modport master (
        output alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, rs1, rs2,
`ifdef REG_WB_FORWARD_EN
        input  fwd_rs1_valid, fwd_rs1_data, fwd_rs2_valid, fwd_rs2_data,
`endif
        input  alu_ready, mem_ready, wb_en, wb_addr, wb_data,
               busy_rs1, busy_rs2, pending_count
    );

    modport slave (
        input  alu_valid, alu_rd, alu_data, mem_valid, mem_rd, mem_data, rs1, rs2,
`ifdef REG_WB_FORWARD_EN
        output fwd_rs1_valid, fwd_rs1_data, fwd_rs2_valid, fwd_rs2_data,
`endif
        output alu_ready, mem_ready, wb_en, wb_addr, wb_data,
               busy_rs1, busy_rs2, pending_count
    );

endinterface

// File: rtl/reg_writeback_ctrl_fifo.sv
// wb_fifo: in-order buffer of pending writes, up to two pushes and one pop
// per cycle. Push slot a is always enqueued ahead of slot b; slot b is only
// used together with slot a.
// Ports: clk, rst_n, push_a_i/ent_a_i, push_b_i/ent_b_i, pop_i, head_o,
// count_o (occupancy), ord_valid_o/ord_rd_o (entries in age order, index 0
// oldest) and, with REG_WB_FORWARD_EN, ord_data_o.
module wb_fifo
    import reg_wb_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 push_a_i,
    input  wb_entry_t            ent_a_i,
    input  logic                 push_b_i,
    input  wb_entry_t            ent_b_i,
    input  logic                 pop_i,
    output wb_entry_t            head_o,
    output logic [$clog2(DEPTH):0] count_o,
    output logic                 ord_valid_o [DEPTH],
`ifdef REG_WB_FORWARD_EN
    output logic [WB_DATA_W-1:0] ord_data_o [DEPTH],
`endif
    output logic [WB_ADDR_W-1:0] ord_rd_o [DEPTH]
);
    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_entry_t       mem_q [DEPTH];
    logic [PW-1:0]   wr_ptr_q;
    logic [PW-1:0]   rd_ptr_q;
    logic [CW-1:0]   count_q;

    // Storage; pointers wrap naturally since DEPTH is a power of two.
    always_ff @(posedge clk) begin
        if (push_a_i) mem_q[wr_ptr_q] <= ent_a_i;
        if (push_b_i) mem_q[wr_ptr_q + PW'(1)] <= ent_b_i;
    end

    // Pointers and occupancy; full/empty come from count_q only.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_q + PW'(push_a_i) + PW'(push_b_i);
            rd_ptr_q <= rd_ptr_q + PW'(pop_i);
            count_q  <= count_q + CW'(push_a_i) + CW'(push_b_i) - CW'(pop_i);
        end
    end

    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    // Age-ordered view for the scoreboard compare.
    always_comb begin
        for (int i = 0; i < DEPTH; i++) begin
            ord_valid_o[i] = CW'(i) < count_q;
            ord_rd_o[i]    = mem_q[rd_ptr_q + PW'(i)].rd;
`ifdef REG_WB_FORWARD_EN
            ord_data_o[i]  = mem_q[rd_ptr_q + PW'(i)].data;
`endif
        end
    end

endmodule

// File: rtl/reg_writeback_ctrl.sv
// reg_writeback_ctrl: collects ALU and load results, buffers them in order
// and issues one registered register file write per cycle, with a pending
// write scoreboard for decode.
// Ports: clk, rst_n (async, active low), bus (reg_wb_if.slave).
// Optional: REG_WB_FORWARD_EN adds youngest-pending-value forwarding.
module reg_writeback_ctrl
    import reg_wb_pkg::*;
#(
    parameter int unsigned DATA_W     = WB_DATA_W,
    parameter int unsigned ADDR_W     = WB_ADDR_W,
    parameter int unsigned FIFO_DEPTH = 4
) (
    input  logic     clk,
    input  logic     rst_n,
    reg_wb_if.slave  bus
);
    localparam int unsigned CNT_W = $clog2(FIFO_DEPTH) + 1;

    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     free_c;
    logic                 mem_ready_c, alu_ready_c;
    logic                 mem_take, alu_take;
    wb_entry_t            mem_e, alu_e, first_e, head, fifo_a, fifo_b;
    logic                 push_a, push_b, pop;
    logic                 ord_valid [FIFO_DEPTH];
    logic [WB_ADDR_W-1:0] ord_rd    [FIFO_DEPTH];
    logic                 wb_en_q, wb_en_d;
    logic [ADDR_W-1:0]    wb_addr_q, wb_addr_d;
    logic [DATA_W-1:0]    wb_data_q, wb_data_d;
    logic                 busy1_c, busy2_c;

    // Readiness uses start-of-cycle occupancy, so the entry drained this
    // cycle still counts as occupied; it never looks at alu_valid.
    assign free_c      = CNT_W'(FIFO_DEPTH) - count;
    assign mem_ready_c = free_c != '0;
    assign alu_ready_c = (free_c >= CNT_W'(2)) || ((free_c == CNT_W'(1)) && !bus.mem_valid);

    // x0 writes complete the handshake but are dropped.
    assign mem_take = bus.mem_valid && mem_ready_c && (bus.mem_rd != ADDR_W'(REG_ZERO));
    assign alu_take = bus.alu_valid && alu_ready_c && (bus.alu_rd != ADDR_W'(REG_ZERO));

    assign mem_e.rd   = WB_ADDR_W'(bus.mem_rd);
    assign mem_e.data = WB_DATA_W'(bus.mem_data);
    assign alu_e.rd   = WB_ADDR_W'(bus.alu_rd);
    assign alu_e.data = WB_DATA_W'(bus.alu_data);
    assign first_e    = mem_take ? mem_e : alu_e;

    // Drain selection: FIFO head when non-empty, otherwise the oldest
    // incoming result bypasses straight into the write stage.
    always_comb begin
        fifo_a    = first_e;
        fifo_b    = alu_e;
        push_a    = 1'b0;
        push_b    = 1'b0;
        pop       = 1'b0;
        wb_en_d   = 1'b0;
        wb_addr_d = wb_addr_q;
        wb_data_d = wb_data_q;
        if (count != '0) begin
            pop       = 1'b1;
            wb_en_d   = 1'b1;
            wb_addr_d = ADDR_W'(head.rd);
            wb_data_d = DATA_W'(head.data);
            push_a    = mem_take || alu_take;
            push_b    = mem_take && alu_take;
        end else if (mem_take || alu_take) begin
            wb_en_d   = 1'b1;
            wb_addr_d = ADDR_W'(first_e.rd);
            wb_data_d = DATA_W'(first_e.data);
            fifo_a    = alu_e;
            push_a    = mem_take && alu_take;
        end
    end

    // Registered write port.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wb_en_q   <= 1'b0;
            wb_addr_q <= '0;
            wb_data_q <= '0;
        end else begin
            wb_en_q   <= wb_en_d;
            wb_addr_q <= wb_addr_d;
            wb_data_q <= wb_data_d;
        end
    end

`ifdef REG_WB_FORWARD_EN
    logic [WB_DATA_W-1:0] ord_data [FIFO_DEPTH];
`endif

    wb_fifo #(
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk         (clk),
        .rst_n       (rst_n),
        .push_a_i    (push_a),
        .ent_a_i     (fifo_a),
        .push_b_i    (push_b),
        .ent_b_i     (fifo_b),
        .pop_i       (pop),
        .head_o      (head),
        .count_o     (count),
        .ord_valid_o (ord_valid),
`ifdef REG_WB_FORWARD_EN
        .ord_data_o  (ord_data),
`endif
        .ord_rd_o    (ord_rd)
    );

    // Scoreboard: any buffered entry or the write in flight this cycle.
    always_comb begin
        busy1_c = wb_en_q && (wb_addr_q == bus.rs1);
        busy2_c = wb_en_q && (wb_addr_q == bus.rs2);
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ord_valid[i] && (ord_rd[i] == WB_ADDR_W'(bus.rs1))) busy1_c = 1'b1;
            if (ord_valid[i] && (ord_rd[i] == WB_ADDR_W'(bus.rs2))) busy2_c = 1'b1;
        end
        if (bus.rs1 == ADDR_W'(REG_ZERO)) busy1_c = 1'b0;
        if (bus.rs2 == ADDR_W'(REG_ZERO)) busy2_c = 1'b0;
    end

`ifdef REG_WB_FORWARD_EN
    logic [DATA_W-1:0] fwd1_data_c, fwd2_data_c;

    // Youngest match wins: start at the write stage, let younger FIFO
    // entries (higher age index) override.
    always_comb begin
        fwd1_data_c = wb_data_q;
        fwd2_data_c = wb_data_q;
        for (int i = 0; i < FIFO_DEPTH; i++) begin
            if (ord_valid[i] && (ord_rd[i] == WB_ADDR_W'(bus.rs1))) fwd1_data_c = DATA_W'(ord_data[i]);
            if (ord_valid[i] && (ord_rd[i] == WB_ADDR_W'(bus.rs2))) fwd2_data_c = DATA_W'(ord_data[i]);
        end
    end

    assign bus.fwd_rs1_valid = busy1_c;
    assign bus.fwd_rs2_valid = busy2_c;
    assign bus.fwd_rs1_data  = busy1_c ? fwd1_data_c : '0;
    assign bus.fwd_rs2_data  = busy2_c ? fwd2_data_c : '0;
`endif

    assign bus.mem_ready     = mem_ready_c;
    assign bus.alu_ready     = alu_ready_c;
    assign bus.wb_en         = wb_en_q;
    assign bus.wb_addr       = wb_addr_q;
    assign bus.wb_data       = wb_data_q;
    assign bus.busy_rs1      = busy1_c;
    assign bus.busy_rs2      = busy2_c;
    assign bus.pending_count = count;

endmodule

// File: tb/tb_reg_writeback_ctrl.sv
// Bench for reg_writeback_ctrl: directed scenarios followed by randomized
// traffic, all checked against a queue-based model of the pending writes.
module tb_reg_writeback_ctrl;

    localparam int unsigned DEPTH = 4;

    typedef struct packed {
        logic [4:0]  rd;
        logic [31:0] data;
    } ent_t;

    logic clk;
    logic rst_n;

    reg_wb_if #(.DATA_W(32), .ADDR_W(5), .FIFO_DEPTH(DEPTH)) bus ();

    reg_writeback_ctrl #(
        .DATA_W     (32),
        .ADDR_W     (5),
        .FIFO_DEPTH (DEPTH)
    ) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_checks = 0;
    int n_pass   = 0;

    // Model: writes accepted but not yet issued, and the issued write.
    ent_t        pend[$];
    logic        m_wb_en   = 1'b0;
    logic [4:0]  m_wb_addr = '0;
    logic [31:0] m_wb_data = '0;
    logic        last_mem_acc = 1'b0;
    logic        last_alu_acc = 1'b0;
    logic        saw_block    = 1'b0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_checks++;
        assert (obs === exp) begin
            n_pass++;
        end else begin
            $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic model_busy(input logic [4:0] rs);
        if (rs == 5'd0) return 1'b0;
        foreach (pend[i]) if (pend[i].rd == rs) return 1'b1;
        return m_wb_en && (m_wb_addr == rs);
    endfunction

    function automatic void model_reset();
        pend.delete();
        m_wb_en   = 1'b0;
        m_wb_addr = '0;
        m_wb_data = '0;
    endfunction

    // One cycle: entered at posedge+1 with inputs set; checks at negedge.
    task automatic step();
        int   free;
        logic e_mr, e_ar;
        ent_t e;
        #4;
        free = int'(DEPTH) - pend.size();
        e_mr = free >= 1;
        e_ar = (free >= 2) || (free == 1 && !bus.mem_valid);
        check("mem_ready", 64'(bus.mem_ready), 64'(e_mr));
        check("alu_ready", 64'(bus.alu_ready), 64'(e_ar));
        check("wb_en", 64'(bus.wb_en), 64'(m_wb_en));
        check("wb_addr", 64'(bus.wb_addr), 64'(m_wb_addr));
        check("wb_data", 64'(bus.wb_data), 64'(m_wb_data));
        check("pending_count", 64'(bus.pending_count), 64'(pend.size()));
        check("busy_rs1", 64'(bus.busy_rs1), 64'(model_busy(bus.rs1)));
        check("busy_rs2", 64'(bus.busy_rs2), 64'(model_busy(bus.rs2)));
        if (bus.alu_valid && bus.mem_valid && !bus.alu_ready) saw_block = 1'b1;
        last_mem_acc = bus.mem_valid && e_mr;
        last_alu_acc = bus.alu_valid && e_ar;
        if (last_mem_acc && bus.mem_rd != 5'd0) pend.push_back('{rd: bus.mem_rd, data: bus.mem_data});
        if (last_alu_acc && bus.alu_rd != 5'd0) pend.push_back('{rd: bus.alu_rd, data: bus.alu_data});
        if (pend.size() > 0) begin
            e = pend.pop_front();
            m_wb_en   = 1'b1;
            m_wb_addr = e.rd;
            m_wb_data = e.data;
        end else begin
            m_wb_en = 1'b0;
        end
        @(posedge clk);
        #1;
    endtask

    initial begin
        rst_n         = 1'b0;
        bus.alu_valid = 1'b0;
        bus.alu_rd    = '0;
        bus.alu_data  = '0;
        bus.mem_valid = 1'b0;
        bus.mem_rd    = '0;
        bus.mem_data  = '0;
        bus.rs1       = '0;
        bus.rs2       = '0;
        repeat (3) @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset state
        check("rst_wb_en", 64'(bus.wb_en), 64'd0);
        check("rst_wb_addr", 64'(bus.wb_addr), 64'd0);
        check("rst_wb_data", 64'(bus.wb_data), 64'd0);
        check("rst_pending", 64'(bus.pending_count), 64'd0);
        check("rst_alu_ready", 64'(bus.alu_ready), 64'd1);
        check("rst_mem_ready", 64'(bus.mem_ready), 64'd1);

        // Single ALU write, one-cycle latency
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd5; bus.alu_data = 32'hDEADBEEF;
        step();
        bus.alu_valid = 1'b0;
        check("t1_wb_en", 64'(bus.wb_en), 64'd1);
        check("t1_wb_addr", 64'(bus.wb_addr), 64'd5);
        check("t1_wb_data", 64'(bus.wb_data), 64'hDEADBEEF);
        step();
        check("t1_wb_en_off", 64'(bus.wb_en), 64'd0);

        // Simultaneous mem + alu into empty FIFO: mem first
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd3; bus.mem_data = 32'h11;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd4; bus.alu_data = 32'h22;
        step();
        bus.mem_valid = 1'b0; bus.alu_valid = 1'b0;
        check("t2_first_addr", 64'(bus.wb_addr), 64'd3);
        step();
        check("t2_second_addr", 64'(bus.wb_addr), 64'd4);
        check("t2_second_data", 64'(bus.wb_data), 64'h22);
        step();

        // Write to x0 is accepted and dropped
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h55;
        step();
        bus.alu_valid = 1'b0;
        step();
        step();

        // Back-to-back dual pushes until free==1, then mem wins the arbitration
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd10; bus.mem_data = 32'd100;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd20; bus.alu_data = 32'd200;
        saw_block = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step();
            if (last_mem_acc) begin bus.mem_rd++; bus.mem_data++; end
            if (last_alu_acc) begin bus.alu_rd++; bus.alu_data++; end
        end
        check("t4_alu_blocked", 64'(saw_block), 64'd1);
        bus.mem_valid = 1'b0;
        for (int k = 0; k < 3 && bus.alu_valid; k++) begin
            step();
            if (last_alu_acc) bus.alu_valid = 1'b0;
        end
        check("t4_alu_drained", 64'(bus.alu_valid), 64'd0);
        repeat (5) step();

        // Scoreboard on rd=7
        bus.rs1 = 5'd7; bus.rs2 = 5'd8;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd7; bus.alu_data = 32'h77;
        step();
        bus.alu_valid = 1'b0;
        check("t5_busy_wb", 64'(bus.busy_rs1), 64'd1);
        step();
        check("t5_busy_clear", 64'(bus.busy_rs1), 64'd0);
        bus.rs1 = 5'd0;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd0; bus.alu_data = 32'h1;
        step();
        bus.alu_valid = 1'b0;
        step();

        // Mid-operation reset discards pending writes
        bus.mem_valid = 1'b1; bus.mem_rd = 5'd12; bus.mem_data = 32'hC;
        bus.alu_valid = 1'b1; bus.alu_rd = 5'd13; bus.alu_data = 32'hD;
        step();
        bus.mem_rd = 5'd14; bus.alu_rd = 5'd15;
        step();
        check("t6_pending_before", 64'(bus.pending_count), 64'd2);
        bus.mem_valid = 1'b0; bus.alu_valid = 1'b0;
        rst_n = 1'b0;
        #1;
        check("t6_rst_wb_en", 64'(bus.wb_en), 64'd0);
        check("t6_rst_pending", 64'(bus.pending_count), 64'd0);
        model_reset();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        repeat (4) step();

        // Randomized traffic with valid held until accepted
        last_mem_acc = 1'b1;
        last_alu_acc = 1'b1;
        for (int c = 0; c < 400; c++) begin
            if (!bus.mem_valid || last_mem_acc) begin
                bus.mem_valid = 1'($urandom_range(0, 1));
                bus.mem_rd    = 5'($urandom_range(0, 7));
                bus.mem_data  = $urandom;
            end
            if (!bus.alu_valid || last_alu_acc) begin
                bus.alu_valid = 1'($urandom_range(0, 1));
                bus.alu_rd    = 5'($urandom_range(0, 7));
                bus.alu_data  = $urandom;
            end
            bus.rs1 = 5'($urandom_range(0, 7));
            bus.rs2 = 5'($urandom_range(0, 7));
            step();
        end
        bus.mem_valid = 1'b0;
        bus.alu_valid = 1'b0;
        repeat (6) step();

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
